// File: rtl/y86_pkg.sv
// Shared Y86 encodings: icodes, jXX/cmovXX ifuns, CC bit layout and reset value.
// Pure definitions; no logic, latency or flow control.
package y86_pkg;

  localparam int CC_W = 3;

  // Flag positions inside cc/alu_cc: {ZF,SF,OF}
  localparam int ZF_B = 2;
  localparam int SF_B = 1;
  localparam int OF_B = 0;

  localparam logic [CC_W-1:0] CC_RST = 3'b100;

  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

endpackage

// File: rtl/cond_eval.sv
// Evaluates a jXX/cmovXX ifun against a {ZF,SF,OF} flag triple.
// Purely combinational, zero latency; no flow control.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0]      ifun,
  input  logic [CC_W-1:0] cc,
  output logic            cnd
);

  logic zf;
  logic lt;

  assign zf = cc[ZF_B];
  assign lt = cc[SF_B] ^ cc[OF_B];

  // Reserved and unknown ifuns fall to the default and never take
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_reg_cond.sv
// Execute-stage CC register plus jXX/cmovXX condition, carried to memory in m_cnd.
// CC and m_cnd visible one cycle after their edge; e_stall holds both, m_bubble inserts a NOP.
module cc_reg_cond
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      e_icode,
  input  logic [3:0]      e_ifun,
  input  logic [CC_W-1:0] alu_cc,
  input  logic            set_cc,
  input  logic            e_stall,
  input  logic            m_bubble,
  output logic [CC_W-1:0] cc,
  output logic            e_cnd,
  output logic            m_cnd,
  output logic            m_valid
);

  logic cc_we;
  logic is_cond_op;
  logic cnd_raw;

  // Equality compares keep an unknown icode from writing CC
  assign cc_we = (e_icode == I_OPQ) && set_cc && !e_stall;

  always_comb begin
    is_cond_op = 1'b0;
    case (e_icode)
      I_JXX, I_CMOV: is_cond_op = 1'b1;
      default:       is_cond_op = 1'b0;
    endcase
  end

  // Condition is taken from the registered flags, never from this cycle's ALU output
  cond_eval u_cond_eval (
    .ifun (e_ifun),
    .cc   (cc),
    .cnd  (cnd_raw)
  );

  assign e_cnd = is_cond_op ? cnd_raw : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc <= CC_RST;
    end else if (cc_we) begin
      cc <= alu_cc;
    end
  end

  // Stall outranks bubble so a held instruction is never squashed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnd   <= 1'b0;
      m_valid <= 1'b0;
    end else if (e_stall) begin
      m_cnd   <= m_cnd;
      m_valid <= m_valid;
    end else if (m_bubble) begin
      m_cnd   <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      m_cnd   <= e_cnd;
      m_valid <= 1'b1;
    end
  end

endmodule
